muxn_arb: RTL and testbench

Parametrised N-channel, WIDTH-bit selector with per-channel valid/ready handshakes and a registered, two-entry output stage. It replaces bare combinational 2:1 selectors wherever a datapath source is produced over several cycles, such as memory, the multiply/divide unit or CP0 returning into the register-file write-back path. Channel choice comes from an externally driven select (MODE 0) or from a built-in round-robin arbiter (MODE 1). Data leaves in acceptance order with one cycle of latency at full throughput.

---
 rtl/mux_pkg.sv | 11 +
 rtl/mux_rr_arb.sv | 45 ++++
 rtl/muxn_arb.sv | 100 ++++++++++
 tb/tb_muxn_arb.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared mode constants and select-width helper for the muxn_arb family.
package mux_pkg;

  localparam int MUX_MODE_SEL = 0;
  localparam int MUX_MODE_RR  = 1;

  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_rr_arb.sv
// rtl/mux_rr_arb.sv - round-robin arbiter: first requester at or above ptr wins, ptr moves past the winner.
module mux_rr_arb
  import mux_pkg::*;
#(
  parameter int N = 4,
  localparam int SEL_W = sel_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic             grant_valid,
  output logic [SEL_W-1:0] grant_idx
);

  logic [SEL_W-1:0] ptr;
  logic [N-1:0]     req_rot;
  logic [SEL_W:0]   idx_sum;

  // Rotate so ptr sits at bit 0, pick the lowest set bit, then rotate the index back.
  always_comb begin
    req_rot     = N'({req, req} >> ptr);
    grant_valid = 1'b0;
    idx_sum     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        grant_valid = 1'b1;
        idx_sum     = {1'b0, ptr} + (SEL_W + 1)'(k);
      end
    end
    if (idx_sum >= (SEL_W + 1)'(N)) begin
      idx_sum = idx_sum - (SEL_W + 1)'(N);
    end
    grant_idx = idx_sum[SEL_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && grant_valid) begin
      ptr <= (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/muxn_arb.sv
// rtl/muxn_arb.sv - N-channel valid/ready selector with external or round-robin grant and a main+skid output stage.
module muxn_arb
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = MUX_MODE_SEL,
  localparam int SEL_W = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int SEL_SPAN = 1 << SEL_W;

  logic [SEL_SPAN-1:0] valid_pad;
  logic                sel_ok;
  logic                rr_valid;
  logic [SEL_W-1:0]    rr_idx;
  logic                grant_valid;
  logic [SEL_W-1:0]    grant_idx;
  logic [WIDTH-1:0]    grant_data;
  logic                accept;
  logic                pop;
  logic                skid_valid;
  logic [WIDTH-1:0]    skid_data;
  logic [SEL_W-1:0]    skid_chan;

  mux_rr_arb #(.N(N)) u_rr (
    .clk         (clk),
    .rst         (rst),
    .req         (in_valid),
    .advance     (accept && (MODE == MUX_MODE_RR)),
    .grant_valid (rr_valid),
    .grant_idx   (rr_idx)
  );

  // valid_pad covers every sel encoding, so an out-of-range sel reads a zero.
  always_comb begin
    valid_pad          = '0;
    valid_pad[N-1:0]   = in_valid;
    sel_ok             = ({1'b0, sel} < (SEL_W + 1)'(N));
    if (N == 1) begin
      grant_valid = in_valid[0];
      grant_idx   = '0;
    end else if (MODE == MUX_MODE_RR) begin
      grant_valid = rr_valid;
      grant_idx   = rr_idx;
    end else begin
      grant_valid = sel_ok && valid_pad[sel];
      grant_idx   = sel;
    end
    grant_data = in_data[grant_idx*WIDTH +: WIDTH];
    accept     = grant_valid && !skid_valid && !rst;
    in_ready   = accept ? (N'(1) << grant_idx) : '0;
    pop        = out_valid && out_ready;
  end

  // Accept never coincides with a full skid, so skid refill and skid drain are exclusive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_chan   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_chan  <= '0;
    end else if (pop) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_chan   <= skid_chan;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_data <= grant_data;
        out_chan <= grant_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_chan  <= grant_idx;
      end else begin
        skid_valid <= 1'b1;
        skid_data  <= grant_data;
        skid_chan  <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_muxn_arb.sv
// tb/tb_muxn_arb.sv - directed and streaming checks of muxn_arb across select, round-robin and single-channel builds.
module tb_muxn_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb[$];

  // A: N=4 select mode
  logic [127:0] in_data_a;
  logic [3:0]   in_valid_a, in_ready_a;
  logic [1:0]   sel_a, out_chan_a;
  logic [31:0]  out_data_a;
  logic         out_valid_a, out_ready_a;
  // B: N=3 select mode
  logic [95:0]  in_data_b;
  logic [2:0]   in_valid_b, in_ready_b;
  logic [1:0]   sel_b, out_chan_b;
  logic [31:0]  out_data_b;
  logic         out_valid_b, out_ready_b;
  // C: N=4 round-robin
  logic [127:0] in_data_c;
  logic [3:0]   in_valid_c, in_ready_c;
  logic [1:0]   sel_c, out_chan_c;
  logic [31:0]  out_data_c;
  logic         out_valid_c, out_ready_c;
  // D: N=2 select mode
  logic [63:0]  in_data_d;
  logic [1:0]   in_valid_d, in_ready_d;
  logic [0:0]   sel_d, out_chan_d;
  logic [31:0]  out_data_d;
  logic         out_valid_d, out_ready_d;
  // E: N=1, WIDTH=8
  logic [7:0]   in_data_e, out_data_e;
  logic [0:0]   in_valid_e, in_ready_e, sel_e, out_chan_e;
  logic         out_valid_e, out_ready_e;

  muxn_arb #(.WIDTH(32), .N(4), .MODE(0)) u_a (
    .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a), .sel(sel_a),
    .out_data(out_data_a), .out_chan(out_chan_a), .out_valid(out_valid_a), .out_ready(out_ready_a));
  muxn_arb #(.WIDTH(32), .N(3), .MODE(0)) u_b (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b), .sel(sel_b),
    .out_data(out_data_b), .out_chan(out_chan_b), .out_valid(out_valid_b), .out_ready(out_ready_b));
  muxn_arb #(.WIDTH(32), .N(4), .MODE(1)) u_c (
    .clk(clk), .rst(rst), .in_data(in_data_c), .in_valid(in_valid_c), .in_ready(in_ready_c), .sel(sel_c),
    .out_data(out_data_c), .out_chan(out_chan_c), .out_valid(out_valid_c), .out_ready(out_ready_c));
  muxn_arb #(.WIDTH(32), .N(2), .MODE(0)) u_d (
    .clk(clk), .rst(rst), .in_data(in_data_d), .in_valid(in_valid_d), .in_ready(in_ready_d), .sel(sel_d),
    .out_data(out_data_d), .out_chan(out_chan_d), .out_valid(out_valid_d), .out_ready(out_ready_d));
  muxn_arb #(.WIDTH(8), .N(1), .MODE(0)) u_e (
    .clk(clk), .rst(rst), .in_data(in_data_e), .in_valid(in_valid_e), .in_ready(in_ready_e), .sel(sel_e),
    .out_data(out_data_e), .out_chan(out_chan_e), .out_valid(out_valid_e), .out_ready(out_ready_e));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [31:0] chan, input logic [31:0] data);
    logic [63:0] e;
    if (sb.size() > 0) e = sb.pop_front();
    else e = 64'hFFFF_FFFF_FFFF_FFFF;
    chk(tag, {chan, data}, e);
  endtask

  int rr_exp [10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2};
  int cnt, got, cyc, seq0, seq1;
  logic exp_acc, stall_prev, hold_chan;
  logic [1:0] exp_rdy;
  logic [31:0] hold_data;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_data_a = '0; in_valid_a = 4'b0001; sel_a = '0; out_ready_a = 1'b1;
    in_data_b = '0; in_valid_b = '0; sel_b = '0; out_ready_b = 1'b1;
    in_data_c = '0; in_valid_c = '0; sel_c = '0; out_ready_c = 1'b1;
    in_data_d = '0; in_valid_d = '0; sel_d = '0; out_ready_d = 1'b1;
    in_data_e = '0; in_valid_e = '0; sel_e = '0; out_ready_e = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid_a), 64'd0);
    chk("rst_out_data", 64'(out_data_a), 64'd0);
    chk("rst_out_chan", 64'(out_chan_a), 64'd0);
    chk("rst_in_ready", 64'(in_ready_a), 64'd0);
    in_valid_a = '0;
    rst = 1'b0;

    // Reset mid-flight
    @(posedge clk); #1;
    sel_a = 2'd2; in_valid_a = 4'b0100; in_data_a = {32'd0, 32'hDEADBEEF, 32'd0, 32'd0};
    #1;
    chk("midrst_in_ready", 64'(in_ready_a), 64'(4'b0100));
    sb.push_back({32'd2, 32'hDEADBEEF});
    @(posedge clk); #1;
    chk("midrst_out_valid", 64'(out_valid_a), 64'd1);
    sb_pop("midrst_out", 32'(out_chan_a), out_data_a);
    #2 rst = 1'b1;
    #1;
    chk("midrst_async_valid", 64'(out_valid_a), 64'd0);
    chk("midrst_async_data", 64'(out_data_a), 64'd0);
    chk("midrst_in_ready_rst", 64'(in_ready_a), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid_a = '0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("midrst_no_partial", 64'(out_valid_a), 64'd0);
    end

    // Out-of-range select
    sel_b = 2'd3; in_valid_b = 3'b111; in_data_b = {32'h3333, 32'h2222, 32'h1111};
    repeat (5) begin
      #1;
      chk("oor_in_ready", 64'(in_ready_b), 64'd0);
      chk("oor_out_valid", 64'(out_valid_b), 64'd0);
      @(posedge clk); #1;
    end
    in_valid_b = '0;

    // Round-robin rotation, ch1 dropped after six grants
    in_data_c = {32'd3, 32'd2, 32'd1, 32'd0};
    for (int i = 0; i < 10; i++) begin
      in_valid_c = (i < 6) ? 4'b1111 : 4'b1101;
      #1;
      chk("rr_in_ready", 64'(in_ready_c), 64'(4'b0001 << rr_exp[i]));
      sb.push_back({32'(rr_exp[i]), 32'(rr_exp[i])});
      @(posedge clk); #1;
      chk("rr_out_valid", 64'(out_valid_c), 64'd1);
      sb_pop("rr_out", 32'(out_chan_c), out_data_c);
    end
    in_valid_c = '0;
    @(posedge clk); #1;
    chk("rr_drained", 64'(out_valid_c), 64'd0);

    // Backpressure: ptr now 3, so ch0 wins first, then ch1
    out_ready_c = 1'b0; in_valid_c = 4'b0011; in_data_c = {32'd0, 32'd0, 32'hB, 32'hA};
    #1;
    chk("bp_ready0", 64'(in_ready_c), 64'(4'b0001));
    sb.push_back({32'd0, 32'hA});
    @(posedge clk); #1;
    chk("bp_ready1", 64'(in_ready_c), 64'(4'b0010));
    sb.push_back({32'd1, 32'hB});
    chk("bp_main_a", 64'(out_data_c), 64'hA);
    @(posedge clk); #1;
    chk("bp_ready_full", 64'(in_ready_c), 64'd0);
    @(posedge clk); #1;
    chk("bp_ready_still_full", 64'(in_ready_c), 64'd0);
    chk("bp_hold_valid", 64'(out_valid_c), 64'd1);
    sb_pop("bp_out_a", 32'(out_chan_c), out_data_c);
    out_ready_c = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_back", 64'(in_ready_c), 64'(4'b0001));
    sb_pop("bp_out_b", 32'(out_chan_c), out_data_c);
    in_valid_c = '0;
    @(posedge clk); #1;
    chk("bp_drained", 64'(out_valid_c), 64'd0);

    // Streaming with toggling sel and random stalls
    cnt = 0; got = 0; cyc = 0; seq0 = 0; seq1 = 0; stall_prev = 1'b0;
    hold_data = '0; hold_chan = 1'b0;
    while (got < 200 && cyc < 3000) begin
      sel_d = 1'(cyc & 1);
      out_ready_d = 1'($urandom_range(0, 1));
      in_valid_d = 2'($urandom_range(0, 3));
      in_data_d = {4'd1, 28'(seq1), 4'd0, 28'(seq0)};
      #1;
      exp_acc = in_valid_d[sel_d] && (cnt < 2);
      exp_rdy = exp_acc ? (2'b01 << sel_d) : 2'b00;
      chk("stream_ready", 64'(in_ready_d), 64'(exp_rdy));
      chk("stream_valid", 64'(out_valid_d), 64'(cnt > 0));
      if (stall_prev) begin
        chk("stream_hold_data", 64'(out_data_d), 64'(hold_data));
        chk("stream_hold_chan", 64'(out_chan_d), 64'(hold_chan));
      end
      if (cnt > 0 && out_ready_d) begin
        sb_pop("stream_out", 32'(out_chan_d), out_data_d);
        got++;
        cnt--;
      end
      stall_prev = (cnt > 0) && !out_ready_d;
      hold_data = out_data_d;
      hold_chan = out_chan_d;
      if (exp_acc) begin
        if (sel_d == 1'b0) begin
          sb.push_back({32'd0, 4'd0, 28'(seq0)});
          seq0++;
        end else begin
          sb.push_back({32'd1, 4'd1, 28'(seq1)});
          seq1++;
        end
        cnt++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("stream_count", 64'(got), 64'd200);
    in_valid_d = '0;
    out_ready_d = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sb.delete();

    // Single channel
    in_data_e = 8'h5A; in_valid_e = 1'b1;
    #1;
    chk("single_ready", 64'(in_ready_e), 64'd1);
    sb.push_back({32'd0, 32'h5A});
    @(posedge clk); #1;
    in_valid_e = 1'b0;
    chk("single_valid", 64'(out_valid_e), 64'd1);
    sb_pop("single_out", 32'(out_chan_e), 32'(out_data_e));
    @(posedge clk); #1;
    chk("single_drained", 64'(out_valid_e), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
